// File: rtl/vga_pkg.sv
// Shared pixel-format definitions for the VGA pixel path: slot geometry,
// RGB colour type and the slot-to-colour unpacking helper.
package vga_pkg;

  localparam int PXL_SLOT_WIDTH = 16;
  localparam int COLOUR_DEPTH   = 4;

  typedef struct packed {
    logic [COLOUR_DEPTH-1:0] red;
    logic [COLOUR_DEPTH-1:0] green;
    logic [COLOUR_DEPTH-1:0] blue;
  } rgb_t;

  // Bits above the 12 colour bits in a slot carry no meaning and are dropped.
  function automatic rgb_t slot_to_rgb(input logic [PXL_SLOT_WIDTH-1:0] slot);
    logic [3*COLOUR_DEPTH-1:0] bits;
    bits = (3*COLOUR_DEPTH)'(slot);
    return rgb_t'(bits);
  endfunction

endpackage

// File: rtl/vga_sync_fifo.sv
// Generic single-clock FIFO with extra-MSB pointers, combinational head word,
// fill level and a synchronous flush that overrides any write/read that cycle.
module vga_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  assign wr_fire = wr_en && !full && !clear;
  assign rd_fire = rd_en && !empty && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage entries are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/vga_pxl_buffer.sv
// Word buffer between the AXI memory master and the VGA colour stage: stores
// 64-bit words, then emits one RGB pixel per pixel-enable, slot 0 first.
module vga_pxl_buffer
  import vga_pkg::rgb_t;
  import vga_pkg::slot_to_rgb;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int PXL_SLOT_WIDTH = 16,
  parameter int COLOUR_DEPTH   = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic                          wr_valid_i,
  output logic                          wr_rdy_o,
  input  logic                          pxl_en_i,
  output logic [COLOUR_DEPTH-1:0]       red_o,
  output logic [COLOUR_DEPTH-1:0]       green_o,
  output logic [COLOUR_DEPTH-1:0]       blue_o,
  output logic                          pxl_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_lvl_o,
  output logic                          underflow_o
);

  localparam int SLOTS = DATA_WIDTH / PXL_SLOT_WIDTH;
  localparam int SEL_W = $clog2(SLOTS);
  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(SLOTS - 1);

  logic [DATA_WIDTH-1:0]     head_word;
  logic [PXL_SLOT_WIDTH-1:0] slot_p0;
  logic                      full;
  logic                      empty;
  logic                      take_pxl;
  logic                      release_word;
  logic [SEL_W-1:0]          sel;
  rgb_t                      rgb_p1;
  logic                      vld_p1;
  logic                      underflow;

  vga_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear_i),
    .wr_en   (wr_valid_i),
    .wr_data (wr_data_i),
    .rd_en   (release_word),
    .rd_data (head_word),
    .full    (full),
    .empty   (empty),
    .level   (fill_lvl_o)
  );

  assign wr_rdy_o     = !full;
  assign take_pxl     = pxl_en_i && !empty;
  assign release_word = take_pxl && (sel == LAST_SLOT);
  assign slot_p0      = head_word[int'(sel)*PXL_SLOT_WIDTH +: PXL_SLOT_WIDTH];

  // Stage p0 -> p1: slot select registered into the colour output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= '0;
      rgb_p1    <= '0;
      vld_p1    <= 1'b0;
      underflow <= 1'b0;
    end else if (clear_i) begin
      sel       <= '0;
      rgb_p1    <= '0;
      vld_p1    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (take_pxl) begin
        rgb_p1 <= slot_to_rgb(slot_p0);
        vld_p1 <= 1'b1;
        sel    <= (sel == LAST_SLOT) ? '0 : sel + 1'b1;
      end else begin
        rgb_p1 <= '0;
        vld_p1 <= 1'b0;
      end
      if (pxl_en_i && empty) underflow <= 1'b1;
    end
  end

  assign red_o       = rgb_p1.red;
  assign green_o     = rgb_p1.green;
  assign blue_o      = rgb_p1.blue;
  assign pxl_valid_o = vld_p1;
  assign underflow_o = underflow;

endmodule
